alu_src2_stage: RTL and testbench

Parametrised ALU operand-B generator with a registered, elastic output between decode and execute. It decodes every RV32/RV64 immediate format directly from the raw instruction word, sign-extended to XLEN from instr[31]. It then selects between RS2, an immediate, or the constant 4, and holds the result in a 2-entry skid buffer with valid/ready handshakes. Flush support lets branches squash in-flight operands.

---
 rtl/alu_src2_stage.sv | 140 ++++++++++++++
 tb/tb_alu_src2_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_src2_stage.sv
// ALU operand-B generator: decodes RV32/RV64 immediates from the raw
// instruction word, selects rs2 / immediate / constant 4, and presents the
// result through a 2-entry skid buffer with valid/ready on both sides.
module alu_src2_stage #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 5,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  rs2,
    input  logic [2:0]       sel,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] SEL_RS2   = 3'd0;
    localparam logic [2:0] SEL_IMM_I = 3'd1;
    localparam logic [2:0] SEL_IMM_S = 3'd2;
    localparam logic [2:0] SEL_SHAMT = 3'd3;
    localparam logic [2:0] SEL_IMM_U = 3'd4;
    localparam logic [2:0] SEL_IMM_B = 3'd5;
    localparam logic [2:0] SEL_IMM_J = 3'd6;

    // Opcode field never contributes to operand B.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    logic [31:0]     imm32;
    logic [XLEN-1:0] op;

    // Decode the selected operand; sign-extended formats are assembled as a
    // 32-bit value first, then widened by a signed cast so XLEN=64 copies instr[31].
    always_comb begin
        imm32 = '0;
        op    = '0;
        case (sel)
            SEL_RS2:   op = rs2;
            SEL_IMM_I: begin
                imm32 = {{20{instr[31]}}, instr[31:20]};
                op    = XLEN'($signed(imm32));
            end
            SEL_IMM_S: begin
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                op    = XLEN'($signed(imm32));
            end
            SEL_SHAMT: op = XLEN'(instr[20 +: SHAMT_W]);
            SEL_IMM_U: begin
                imm32 = {instr[31:12], 12'b0};
                op    = XLEN'($signed(imm32));
            end
            SEL_IMM_B: begin
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                op    = XLEN'($signed(imm32));
            end
            SEL_IMM_J: begin
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                op    = XLEN'($signed(imm32));
            end
            default:   op = XLEN'(32'd4);
        endcase
    end

    logic             m_valid_q, m_valid_d;
    logic [XLEN-1:0]  m_data_q,  m_data_d;
    logic [TAG_W-1:0] m_tag_q,   m_tag_d;
    logic             s_valid_q, s_valid_d;
    logic [XLEN-1:0]  s_data_q,  s_data_d;
    logic [TAG_W-1:0] s_tag_q,   s_tag_d;

    logic accept, pop;

    // in_ready comes straight off the skid valid flop, so upstream never
    // sees a combinational path from out_ready.
    assign in_ready  = ~s_valid_q;
    assign accept    = in_valid & in_ready;
    assign pop       = m_valid_q & out_ready;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    assign out_tag   = m_tag_q;

    // Skid-buffer next state: flush wins, then refill M (from S first to keep
    // FIFO order), otherwise park a new operand in S while M is stalled.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_tag_d   = m_tag_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_tag_d   = s_tag_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || pop) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data_q;
                m_tag_d   = s_tag_q;
            end else if (accept) begin
                m_valid_d = 1'b1;
                m_data_d  = op;
                m_tag_d   = tag_in;
            end else begin
                m_valid_d = 1'b0;
            end
            s_valid_d = 1'b0;
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = op;
            s_tag_d   = tag_in;
        end
    end

    // State registers; reset clears valids and data so outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_tag_q   <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_tag_q   <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_tag_q   <= m_tag_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            s_tag_q   <= s_tag_d;
        end
    end

endmodule

// File: tb/tb_alu_src2_stage.sv
// Scoreboard bench: a 32-bit and a 64-bit instance share all inputs; the
// stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_alu_src2_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [63:0] rs2;
    logic [2:0]  sel;
    logic [4:0]  tag_in;
    logic        out_ready;

    logic        in_ready32, out_valid32, in_ready64, out_valid64;
    logic [31:0] out_data32;
    logic [63:0] out_data64;
    logic [4:0]  out_tag32, out_tag64;

    always #5 clk = ~clk;

    alu_src2_stage #(.XLEN(32), .TAG_W(5), .SHAMT_W(5)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .rs2(rs2[31:0]), .sel(sel), .tag_in(tag_in),
        .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32), .out_tag(out_tag32)
    );

    alu_src2_stage #(.XLEN(64), .TAG_W(5), .SHAMT_W(6)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .rs2(rs2), .sel(sel), .tag_in(tag_in),
        .out_valid(out_valid64), .out_ready(out_ready), .out_data(out_data64), .out_tag(out_tag64)
    );

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] e32;
        logic [63:0] e64;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: mid-cycle, after the stimulus has settled, compare whatever
    // will be popped on the next rising edge against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid32 && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {59'd0, out_tag32}, 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("data32", {32'd0, out_data32}, {32'd0, e.e32});
                    chk("tag32", {59'd0, out_tag32}, {59'd0, e.tag});
                    chk("valid64", {63'd0, out_valid64}, 64'd1);
                    chk("data64", out_data64, e.e64);
                    chk("tag64", {59'd0, out_tag64}, {59'd0, e.tag});
                end
            end
        end
    end

    // Present an operand and hold it until accepted (bounded), pushing the
    // expectation at the accepting edge.
    task automatic send(input logic [2:0] s, input logic [31:0] ins, input logic [63:0] r,
                        input logic [4:0] t, input logic [31:0] e32, input logic [63:0] e64);
        bit acc;
        @(negedge clk);
        in_valid = 1'b1; sel = s; instr = ins; rs2 = r; tag_in = t;
        for (int i = 0; i < 20; i++) begin
            acc = in_ready32;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back('{tag: t, e32: e32, e64: e64});
                return;
            end
            @(negedge clk);
        end
        chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; rs2 = '0;
        sel = '0; tag_in = '0; out_ready = 1'b1;

        // Reset state
        #3;
        chk("rst_out_valid", {63'd0, out_valid32}, 64'd0);
        chk("rst_out_data", {32'd0, out_data32}, 64'd0);
        chk("rst_out_tag", {59'd0, out_tag32}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready32}, 64'd1);
        chk("rst_out_data64", out_data64, 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Immediate formats, back-to-back at full throughput
        send(3'd1, 32'hFFF00000, 64'h5, 5'd1, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF);
        send(3'd1, 32'h7FF00000, 64'h5, 5'd2, 32'h000007FF, 64'h00000000_000007FF);
        send(3'd2, 32'hFE000E00, 64'h0, 5'd3, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC);
        send(3'd5, 32'hFE000F80, 64'h0, 5'd4, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFFE);
        send(3'd4, 32'h12345000, 64'h0, 5'd5, 32'h12345000, 64'h00000000_12345000);
        send(3'd3, 32'h81F00000, 64'h0, 5'd6, 32'h0000001F, 64'h00000000_0000001F);
        send(3'd3, 32'h83F00000, 64'h0, 5'd7, 32'h0000001F, 64'h00000000_0000003F);
        send(3'd7, 32'hFFFFFFFF, 64'h0, 5'd8, 32'h00000004, 64'h00000000_00000004);
        send(3'd4, 32'h80000000, 64'h0, 5'd9, 32'h80000000, 64'hFFFFFFFF_80000000);
        send(3'd6, 32'h80000000, 64'h0, 5'd10, 32'hFFF00000, 64'hFFFFFFFF_FFF00000);
        send(3'd6, 32'h7FFFF000, 64'h0, 5'd11, 32'h000FFFFE, 64'h00000000_000FFFFE);
        send(3'd0, 32'hFFFFFFFF, 64'h12345678_9ABCDEF0, 5'd12, 32'h9ABCDEF0, 64'h12345678_9ABCDEF0);
        idle(4);

        // Backpressure: fill M and S, upstream holds tag 3
        @(negedge clk); out_ready = 1'b0;
        send(3'd0, 32'h0, 64'hA, 5'd1, 32'hA, 64'hA);
        send(3'd0, 32'h0, 64'hB, 5'd2, 32'hB, 64'hB);
        @(negedge clk);
        in_valid = 1'b1; sel = 3'd0; rs2 = 64'hC; tag_in = 5'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready_low", {63'd0, in_ready32}, 64'd0);
            chk("bp_out_stable", {32'd0, out_data32}, 64'hA);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(3'd0, 32'h0, 64'hC, 5'd3, 32'hC, 64'hC);
        idle(4);

        // Flush with a valid input in the same cycle
        @(negedge clk); out_ready = 1'b0;
        send(3'd0, 32'h0, 64'h11, 5'd4, 32'h11, 64'h11);
        send(3'd0, 32'h0, 64'h22, 5'd5, 32'h22, 64'h22);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; sel = 3'd0; rs2 = 64'h33; tag_in = 5'd6;
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_out_valid", {63'd0, out_valid32}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready32}, 64'd1);
        out_ready = 1'b1;
        send(3'd0, 32'h0, 64'h44, 5'd7, 32'h44, 64'h44);
        idle(4);

        // Asynchronous reset between edges with M and S full
        @(negedge clk); out_ready = 1'b0;
        send(3'd0, 32'h0, 64'h55, 5'd8, 32'h55, 64'h55);
        send(3'd0, 32'h0, 64'h66, 5'd9, 32'h66, 64'h66);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_out_valid", {63'd0, out_valid32}, 64'd0);
        chk("arst_out_data", {32'd0, out_data32}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready32}, 64'd1);
        chk("arst_out_valid64", {63'd0, out_valid64}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_idle", {63'd0, out_valid32}, 64'd0);
        end

        idle(4);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
